norm_round_unit: RTL and testbench
==================================

// Module: norm_round_unit
// PURPOSE
//  Downstream of the 28-bit mantissa adder in the FP add/sub datapath. Takes raw sum+carry, exponent, sign.
//  Normalises (carry right-shift / leading-zero left-shift), rounds RNE, packs IEEE-754 binary32.
//  2-stage pipeline with valid/ready handshake; sits between mantissa adder and result writeback.
// PARAMETERS
//  SIZE_DATA  28  adder width: [27] hidden bit, [26:4] fraction, [3] guard, [2] round, [1:0] sticky bits
//  SIZE_EXP   8   biased exponent width (bias 127 taken from package)
//  SIZE_MAN   23  stored fraction width
// PORTS
//  i_clk         in   1          clock; all state updates on rising edge
//  i_rst         in   1          synchronous, active-high reset
//  i_valid       in   1          upstream data valid
//  o_ready       out  1          upstream may transfer (i_valid & o_ready)
//  i_sum         in   SIZE_DATA  adder sum
//  i_carry       in   1          adder carry-out (value >= 2.0)
//  i_exp         in   SIZE_EXP   biased exponent of larger operand
//  i_sign        in   1          result sign
//  i_bypass      in   1          special result (NaN/Inf) precomputed upstream
//  i_bypass_val  in   32         special result, passed unchanged
//  o_valid       out  1          result valid
//  i_ready       in   1          downstream accepts (o_valid & i_ready)
//  o_result      out  32         packed binary32 {sign, exp[7:0], frac[22:0]}
// BEHAVIOUR
//  Reset: s1/s2 valid = 0, o_valid = 0, o_result = 0, o_flags = 0; o_ready = 1 the cycle after reset.
//  Pipeline enable en = !o_valid | i_ready; o_ready = en; both stages advance together on en.
//  Latency: 2 cycles from accepted input to o_valid; throughput 1/cycle without backpressure.
//  Stall (en = 0): all stage registers and o_result hold; no item lost or duplicated.
//  S1: register inputs; exp widened to 10-bit signed; lz = leading-zero count of i_sum (0..28).
//   i_carry = 1: mant = {1, i_sum[27:1]}, dropped bit ORed into sticky; exp += 1.
//   i_carry = 0, i_sum != 0: mant = i_sum << lz; exp -= lz.
//   i_carry = 0, i_sum == 0: exact zero; result +0 (0x00000000).
//  S2: G = mant[3], R = mant[2], S = |mant[1:0]; round up iff G & (R | S | mant[4]).
//   Round overflow (frac all ones + 1): frac = 0, exp += 1.
//   exp >= 255 after round: +/-Inf (exp = 0xFF, frac = 0).
//   exp <= 0: flush to signed zero (no subnormals).
//  i_bypass = 1: i_bypass_val rides the pipeline; normalisation is ignored.
//  Reset asserted mid-operation: in-flight items discarded; valids cleared next edge.
// CONFIGURATION
//  FP_NORM_FLAGS_EN defined: extra port o_flags out 4 = {overflow, underflow, inexact, zero}.
//   Flags are aligned with o_result and valid only with o_valid; inexact = G|R|S, computed before round.
//   Bypassed items: flags = 0.
//  FP_NORM_FLAGS_EN undefined: o_flags port and flag logic absent; o_result identical in both builds.
// STRUCTURE
//  fp_pkg: SIZE_EXP, SIZE_MAN, EXP_BIAS = 127, EXP_MAX = 255; typedef fp32_t (packed sign/exp/frac struct);
//   typedef fp_flags_t (packed 4-bit flags); rounding-mode enum (RNE only used here).
//  Sub-module lzc_28: combinational 28-bit leading-zero counter, 5-bit count, all-zero -> 28.
//  Top: S1 normalise-shift registers, S2 round/pack registers, handshake control.
// TESTING
//  Carry: carry=1, sum=0x0000000, exp=127 (1.0+1.0) -> o_result 0x40000000 two cycles later.
//  Cancellation: carry=0, sum=0x4000000, exp=127 -> lz=1 -> 0x3F000000.
//  RNE tie: sum=0x8000018, exp=127 -> 0x3F800002 (odd LSB rounds up);
//   sum=0x8000008 -> 0x3F800000; inexact=1 in both.
//  Round overflow: sum=0xFFFFFF8, exp=127 -> 0x40000000; same with exp=254 -> 0x7F800000, overflow=1.
//  Zero/underflow: sum=0, carry=0 -> 0x00000000, zero=1; sum=0x0000010, exp=5 -> signed zero, underflow=1.
//  Backpressure/reset: stream 4 items, i_ready=0 for 3 cycles -> o_result stable, o_ready=0, in-order output;
//   assert i_rst mid-stream -> o_valid=0 next cycle.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared binary32 types and constants for the FP add/sub normalise/round path.
package fp_pkg;

    localparam int SIZE_DATA = 28;
    localparam int SIZE_EXP  = 8;
    localparam int SIZE_MAN  = 23;
    localparam int EXP_BIAS  = 127;
    localparam int EXP_MAX   = 255;

    typedef struct packed {
        logic                sign;
        logic [SIZE_EXP-1:0] exp;
        logic [SIZE_MAN-1:0] frac;
    } fp32_t;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
        logic zero;
    } fp_flags_t;

    typedef enum logic [1:0] {
        RM_RNE = 2'd0,
        RM_RTZ = 2'd1,
        RM_RDN = 2'd2,
        RM_RUP = 2'd3
    } round_mode_e;

endpackage

// File: rtl/norm_round_unit_if.sv
// Handshake/data bundle between mantissa adder, norm_round_unit and writeback.
// o_flags exists only when FP_NORM_FLAGS_EN is defined.
interface norm_round_unit_if;
    import fp_pkg::*;

    logic                 i_valid;
    logic                 o_ready;
    logic [SIZE_DATA-1:0] i_sum;
    logic                 i_carry;
    logic [SIZE_EXP-1:0]  i_exp;
    logic                 i_sign;
    logic                 i_bypass;
    logic [31:0]          i_bypass_val;
    logic                 o_valid;
    logic                 i_ready;
    logic [31:0]          o_result;
`ifdef FP_NORM_FLAGS_EN
    fp_flags_t            o_flags;

    modport master (output i_valid, i_sum, i_carry, i_exp, i_sign, i_bypass, i_bypass_val, i_ready,
                    input  o_ready, o_valid, o_result, o_flags);
    modport slave  (input  i_valid, i_sum, i_carry, i_exp, i_sign, i_bypass, i_bypass_val, i_ready,
                    output o_ready, o_valid, o_result, o_flags);
`else
    modport master (output i_valid, i_sum, i_carry, i_exp, i_sign, i_bypass, i_bypass_val, i_ready,
                    input  o_ready, o_valid, o_result);
    modport slave  (input  i_valid, i_sum, i_carry, i_exp, i_sign, i_bypass, i_bypass_val, i_ready,
                    output o_ready, o_valid, o_result);
`endif

endinterface

// File: rtl/lzc_28.sv
// Combinational leading-zero counter for the 28-bit adder sum; all-zero input gives 28.
module lzc_28 (
    input  logic [27:0] i_data,
    output logic [4:0]  o_count
);

    // Scanning upward lets the most significant set bit win.
    always_comb begin
        o_count = 5'd28;
        for (int i = 0; i < 28; i++) begin
            if (i_data[i]) o_count = 5'(27 - i);
        end
    end

endmodule

// File: rtl/norm_round_unit.sv
// Normalise, round-to-nearest-even and pack the FP adder result into binary32 (2-stage pipeline).
// Define FP_NORM_FLAGS_EN to add o_flags = {overflow, underflow, inexact, zero}; zero covers flushed results.
module norm_round_unit #(
    parameter int SIZE_DATA = 28,
    parameter int SIZE_EXP  = 8,
    parameter int SIZE_MAN  = 23
) (
    input logic              i_clk,
    input logic              i_rst,
    norm_round_unit_if.slave bus
);
    import fp_pkg::*;

    localparam int EXP_W = SIZE_EXP + 2;
    localparam int LZ_W  = $clog2(SIZE_DATA + 1);
    localparam logic signed [EXP_W-1:0] EXP_INF = EXP_W'(EXP_MAX);

    logic                    en;
    logic [LZ_W-1:0]         lz;
    logic signed [EXP_W-1:0] exp_in;

    logic                    vld_p1_d, vld_p1_q;
    logic [SIZE_DATA-2:0]    mant_p1_d, mant_p1_q;
    logic signed [EXP_W-1:0] exp_p1_d, exp_p1_q;
    logic                    sign_p1_d, sign_p1_q;
    logic                    zero_p1_d, zero_p1_q;
    logic                    byp_p1_d, byp_p1_q;
    logic [31:0]             bval_p1_d, bval_p1_q;

    logic                    g, r, s, rnd_up, is_inf, is_uf;
    logic [SIZE_MAN:0]       frac_rnd;
    logic signed [EXP_W-1:0] exp_rnd;
    logic                    vld_p2_d, vld_p2_q;
    fp32_t                   result_p2_d, result_p2_q;

    lzc_28 u_lzc (
        .i_data  (bus.i_sum),
        .o_count (lz)
    );

    assign en           = !vld_p2_q || bus.i_ready;
    assign bus.o_ready  = en;
    assign bus.o_valid  = vld_p2_q;
    assign bus.o_result = result_p2_q;
    assign exp_in       = signed'({2'b00, bus.i_exp});

    // Stage 1: normalise shift; the hidden bit is implied and not stored.
    always_comb begin
        vld_p1_d  = bus.i_valid;
        sign_p1_d = bus.i_sign;
        byp_p1_d  = bus.i_bypass;
        bval_p1_d = bus.i_bypass_val;
        zero_p1_d = 1'b0;
        mant_p1_d = (SIZE_DATA-1)'(bus.i_sum << lz);
        exp_p1_d  = exp_in - EXP_W'(lz);
        if (bus.i_carry) begin
            mant_p1_d = {bus.i_sum[SIZE_DATA-1:2], bus.i_sum[1] | bus.i_sum[0]};
            exp_p1_d  = exp_in + EXP_W'(1);
        end else if (bus.i_sum == '0) begin
            zero_p1_d = 1'b1;
        end
    end

    // Stage 2: RNE round, exponent range check and pack.
    always_comb begin
        g        = mant_p1_q[3];
        r        = mant_p1_q[2];
        s        = |mant_p1_q[1:0];
        rnd_up   = g & (r | s | mant_p1_q[4]);
        frac_rnd = {1'b0, mant_p1_q[SIZE_DATA-2:4]} + (SIZE_MAN+1)'(rnd_up);
        exp_rnd  = exp_p1_q + EXP_W'(frac_rnd[SIZE_MAN]);
        is_inf   = !byp_p1_q && !zero_p1_q && (exp_rnd >= EXP_INF);
        is_uf    = !byp_p1_q && !zero_p1_q && (exp_rnd[EXP_W-1] || exp_rnd == '0);
        vld_p2_d = vld_p1_q;
        result_p2_d = '{sign: sign_p1_q, exp: exp_rnd[SIZE_EXP-1:0], frac: frac_rnd[SIZE_MAN-1:0]};
        if (byp_p1_q)       result_p2_d = bval_p1_q;
        else if (zero_p1_q) result_p2_d = '0;
        else if (is_inf)    result_p2_d = '{sign: sign_p1_q, exp: '1, frac: '0};
        else if (is_uf)     result_p2_d = '{sign: sign_p1_q, exp: '0, frac: '0};
    end

`ifdef FP_NORM_FLAGS_EN
    fp_flags_t flags_p2_d, flags_p2_q;

    always_comb begin
        flags_p2_d = '0;
        if (!byp_p1_q) begin
            flags_p2_d.overflow  = is_inf;
            flags_p2_d.underflow = is_uf;
            flags_p2_d.inexact   = g | r | s;
            flags_p2_d.zero      = zero_p1_q | is_uf;
        end
    end

    assign bus.o_flags = flags_p2_q;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            result_p2_q <= '0;
`ifdef FP_NORM_FLAGS_EN
            flags_p2_q  <= '0;
`endif
        end else if (en) begin
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            result_p2_q <= result_p2_d;
`ifdef FP_NORM_FLAGS_EN
            flags_p2_q  <= flags_p2_d;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (en) begin
            mant_p1_q <= mant_p1_d;
            exp_p1_q  <= exp_p1_d;
            sign_p1_q <= sign_p1_d;
            zero_p1_q <= zero_p1_d;
            byp_p1_q  <= byp_p1_d;
            bval_p1_q <= bval_p1_d;
        end
    end

endmodule

// File: tb/tb_norm_round_unit.sv
// Scoreboard bench for norm_round_unit; flag checks are added when FP_NORM_FLAGS_EN is defined.
module tb_norm_round_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [35:0] exp_q[$];
    logic [35:0] got_q[$];

    norm_round_unit_if bus();

    norm_round_unit dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
`ifdef FP_NORM_FLAGS_EN
            got_q.push_back({bus.o_result, bus.o_flags});
`else
            got_q.push_back({bus.o_result, 4'b0000});
`endif
        end
    end

    // Presents one item from posedge+1 until accepted; expectation is queued at the handshake.
    task automatic drive(input logic [27:0] sum, input logic carry, input logic [7:0] e,
                         input logic sg, input logic byp, input logic [31:0] bval,
                         input logic [31:0] er, input logic [3:0] ef);
        bit taken = 1'b0;
        bus.i_sum = sum; bus.i_carry = carry; bus.i_exp = e; bus.i_sign = sg;
        bus.i_bypass = byp; bus.i_bypass_val = bval; bus.i_valid = 1'b1;
        for (int k = 0; k < 50 && !taken; k++) begin
            @(negedge clk);
            if (bus.o_ready === 1'b1) begin
                exp_q.push_back({er, ef});
                taken = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
        if (!taken) begin
            n_fail++;
            $display("FAIL drive_accept: o_ready never high, expected acceptance within 50 cycles");
        end
    endtask

    task automatic test_reset;
        bus.i_valid = 0; bus.i_sum = '0; bus.i_carry = 0; bus.i_exp = '0; bus.i_sign = 0;
        bus.i_bypass = 0; bus.i_bypass_val = '0; bus.i_ready = 1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %b expected 0", bus.o_valid); end
        n_checks++;
        if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_o_ready: got %b expected 1", bus.o_ready); end
        n_checks++;
        if (bus.o_result !== 32'h0) begin n_fail++; $display("FAIL reset_o_result: got %h expected 00000000", bus.o_result); end
`ifdef FP_NORM_FLAGS_EN
        n_checks++;
        if (bus.o_flags !== 4'b0) begin n_fail++; $display("FAIL reset_o_flags: got %b expected 0000", bus.o_flags); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_normalise;
        logic [35:0] e, g;
        drive(28'h0000000, 1, 8'd127, 0, 0, 32'h0,        32'h40000000, 4'b0000);
        drive(28'h4000000, 0, 8'd127, 0, 0, 32'h0,        32'h3F000000, 4'b0000);
        drive(28'h8000000, 1, 8'd127, 1, 0, 32'h0,        32'hC0400000, 4'b0000);
        drive(28'h0000011, 1, 8'd127, 0, 0, 32'h0,        32'h40000001, 4'b0010);
        drive(28'h1234567, 0, 8'd127, 0, 1, 32'h7FC00000, 32'h7FC00000, 4'b0000);
        drive(28'h0000100, 0, 8'd127, 0, 0, 32'h0,        32'h36000000, 4'b0000);
        for (int k = 0; k < 100 && got_q.size() < exp_q.size(); k++) begin @(posedge clk); #1; end
        n_checks++;
        if (got_q.size() < exp_q.size()) begin n_fail++; $display("FAIL normalise_drain: got %0d results expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++;
            if (g[35:4] !== e[35:4]) begin n_fail++; $display("FAIL normalise_result: got %h expected %h", g[35:4], e[35:4]); end
`ifdef FP_NORM_FLAGS_EN
            n_checks++;
            if (g[3:0] !== e[3:0]) begin n_fail++; $display("FAIL normalise_flags: got %b expected %b", g[3:0], e[3:0]); end
`endif
        end
    endtask

    task automatic test_rounding;
        logic [35:0] e, g;
        drive(28'h8000018, 0, 8'd127, 0, 0, 32'h0, 32'h3F800002, 4'b0010);
        drive(28'h8000008, 0, 8'd127, 0, 0, 32'h0, 32'h3F800000, 4'b0010);
        drive(28'h800000C, 0, 8'd127, 0, 0, 32'h0, 32'h3F800001, 4'b0010);
        drive(28'h8000007, 0, 8'd127, 0, 0, 32'h0, 32'h3F800000, 4'b0010);
        drive(28'hFFFFFF8, 0, 8'd127, 0, 0, 32'h0, 32'h40000000, 4'b0010);
        drive(28'hFFFFFF8, 0, 8'd254, 0, 0, 32'h0, 32'h7F800000, 4'b1010);
        for (int k = 0; k < 100 && got_q.size() < exp_q.size(); k++) begin @(posedge clk); #1; end
        n_checks++;
        if (got_q.size() < exp_q.size()) begin n_fail++; $display("FAIL rounding_drain: got %0d results expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++;
            if (g[35:4] !== e[35:4]) begin n_fail++; $display("FAIL rounding_result: got %h expected %h", g[35:4], e[35:4]); end
`ifdef FP_NORM_FLAGS_EN
            n_checks++;
            if (g[3:0] !== e[3:0]) begin n_fail++; $display("FAIL rounding_flags: got %b expected %b", g[3:0], e[3:0]); end
`endif
        end
    endtask

    task automatic test_range;
        logic [35:0] e, g;
        drive(28'h0000000, 0, 8'd127, 1, 0, 32'h0, 32'h00000000, 4'b0001);
        drive(28'h0000010, 0, 8'd5,   1, 0, 32'h0, 32'h80000000, 4'b0101);
        drive(28'h4000000, 0, 8'd1,   0, 0, 32'h0, 32'h00000000, 4'b0101);
        drive(28'h4000000, 0, 8'd2,   0, 0, 32'h0, 32'h00800000, 4'b0000);
        drive(28'h8000000, 0, 8'd254, 0, 0, 32'h0, 32'h7F000000, 4'b0000);
        drive(28'h0000000, 1, 8'd254, 1, 0, 32'h0, 32'hFF800000, 4'b1000);
        for (int k = 0; k < 100 && got_q.size() < exp_q.size(); k++) begin @(posedge clk); #1; end
        n_checks++;
        if (got_q.size() < exp_q.size()) begin n_fail++; $display("FAIL range_drain: got %0d results expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++;
            if (g[35:4] !== e[35:4]) begin n_fail++; $display("FAIL range_result: got %h expected %h", g[35:4], e[35:4]); end
`ifdef FP_NORM_FLAGS_EN
            n_checks++;
            if (g[3:0] !== e[3:0]) begin n_fail++; $display("FAIL range_flags: got %b expected %b", g[3:0], e[3:0]); end
`endif
        end
    endtask

    task automatic test_back_to_back;
        logic [35:0] e, g;
        fork
            begin
                drive(28'h8000000, 0, 8'd120, 0, 0, 32'h0, 32'h3C000000, 4'b0000);
                drive(28'h8000000, 0, 8'd121, 0, 0, 32'h0, 32'h3C800000, 4'b0000);
                drive(28'h8000000, 0, 8'd122, 0, 0, 32'h0, 32'h3D000000, 4'b0000);
                drive(28'h8000000, 0, 8'd123, 0, 0, 32'h0, 32'h3D800000, 4'b0000);
            end
            begin
                logic [31:0] hold;
                bit seen = 1'b0;
                for (int k = 0; k < 20 && !seen; k++) begin
                    @(posedge clk); #1;
                    if (bus.o_valid === 1'b1) seen = 1'b1;
                end
                n_checks++;
                if (!seen) begin n_fail++; $display("FAIL stall_first_valid: got o_valid=0 expected 1 within 20 cycles"); end
                if (seen) begin
                    hold = bus.o_result;
                    bus.i_ready = 1'b0;
                    repeat (3) begin
                        @(negedge clk);
                        n_checks++;
                        if (bus.o_result !== hold) begin n_fail++; $display("FAIL stall_result_hold: got %h expected %h", bus.o_result, hold); end
                        n_checks++;
                        if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL stall_o_ready: got %b expected 0", bus.o_ready); end
                    end
                    @(posedge clk); #1;
                    bus.i_ready = 1'b1;
                end
            end
        join
        for (int k = 0; k < 100 && got_q.size() < exp_q.size(); k++) begin @(posedge clk); #1; end
        n_checks++;
        if (got_q.size() != 4) begin n_fail++; $display("FAIL stream_count: got %0d results expected 4", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++;
            if (g[35:4] !== e[35:4]) begin n_fail++; $display("FAIL stream_order: got %h expected %h", g[35:4], e[35:4]); end
        end
    endtask

    task automatic test_reset_mid;
        bit leaked = 1'b0;
        bus.i_sum = 28'h8000000; bus.i_carry = 0; bus.i_exp = 8'd127; bus.i_sign = 0; bus.i_bypass = 0;
        bus.i_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_o_valid: got %b expected 0", bus.o_valid); end
        n_checks++;
        if (bus.o_result !== 32'h0) begin n_fail++; $display("FAIL midreset_o_result: got %h expected 00000000", bus.o_result); end
        n_checks++;
        if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_o_ready: got %b expected 1", bus.o_ready); end
        @(posedge clk); #1;
        bus.i_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.o_valid !== 1'b0) leaked = 1'b1;
        end
        n_checks++;
        if (leaked) begin n_fail++; $display("FAIL midreset_discard: got o_valid=1 after reset expected 0"); end
        exp_q.delete();
        got_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_normalise();
        test_rounding();
        test_range();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
